// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the five-stage MIPS core: ALU op codes,
// opcode/funct encodings, and the bit layout of the 14-bit control word.
package cpu_ctrl_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type funct codes
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  // Control word layout, MSB first: the only place the bundle order lives
  localparam int CTRL_W          = 14;
  localparam int CTRL_MEM_TO_REG = 13;
  localparam int CTRL_MEM_WRITE  = 12;
  localparam int CTRL_ALU_SRC    = 11;
  localparam int CTRL_REG_WRITE  = 10;
  localparam int CTRL_SYSCALL    = 9;
  localparam int CTRL_REG_DST    = 8;
  localparam int CTRL_BEQ        = 7;
  localparam int CTRL_BNE        = 6;
  localparam int CTRL_JR         = 5;
  localparam int CTRL_JMP        = 4;
  localparam int CTRL_JAL        = 3;
  localparam int CTRL_BGEZ       = 2;
  localparam int CTRL_SV         = 1;
  localparam int CTRL_LBU        = 0;

  localparam logic [4:0] REG_RA = 5'd31;

  // jal links into $ra; R-type writes rd; everything else writes rt.
  function automatic logic [4:0] resolve_wr_reg(input logic [CTRL_W-1:0] ctrl,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
    if (ctrl[CTRL_JAL])
      return REG_RA;
    else if (ctrl[CTRL_REG_DST])
      return rd;
    else
      return rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: an ID instruction that reads the
// destination of a load sitting in EX must wait one cycle.
module load_use_detect (
  input  logic       id_valid,
  input  logic       flush,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_reg_dst,
  input  logic       id_mem_write,
  input  logic       id_beq,
  input  logic       id_bne,
  input  logic       id_sv,
  input  logic       ex_valid,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_wr_reg,
  output logic       load_use_stall
);

  logic rt_used;
  logic hazard;

  // rt is a source only for R-type ops, stores, two-register branches and sv.
  assign rt_used = id_reg_dst | id_mem_write | id_beq | id_bne | id_sv;

  assign hazard = ex_valid & ex_mem_to_reg & (ex_wr_reg != 5'd0) &
                  ((ex_wr_reg == id_rs) | (rt_used & (ex_wr_reg == id_rt)));

  // A flush discards the ID instruction, so stalling it would only delay the refetch.
  assign load_use_stall = id_valid & hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush squashing
// and cycle/bubble/flush performance counters.
module id_ex_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm_ext,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_op,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm_ext,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_wr_reg,
  output logic [3:0]        ex_alu_op,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic       take_id;
  logic [4:0] id_wr_reg;

  load_use_detect u_load_use_detect (
    .id_valid       (id_valid),
    .flush          (flush),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_reg_dst     (id_ctrl[CTRL_REG_DST]),
    .id_mem_write   (id_ctrl[CTRL_MEM_WRITE]),
    .id_beq         (id_ctrl[CTRL_BEQ]),
    .id_bne         (id_ctrl[CTRL_BNE]),
    .id_sv          (id_ctrl[CTRL_SV]),
    .ex_valid       (ex_valid),
    .ex_mem_to_reg  (ex_ctrl[CTRL_MEM_TO_REG]),
    .ex_wr_reg      (ex_wr_reg),
    .load_use_stall (load_use_stall)
  );

  // Anything other than a real, unstalled, unflushed instruction becomes an all-zero bubble.
  assign take_id   = id_valid & ~flush & ~load_use_stall;
  assign id_wr_reg = resolve_wr_reg(id_ctrl, id_rt, id_rd);

  // NOTE: every register here is state, so it is assigned with <= only; blocking
  // assignments would let later statements see this edge's new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm_ext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_shamt   <= '0;
      ex_wr_reg  <= '0;
      ex_alu_op  <= '0;
      ex_ctrl    <= '0;
    end else if (en) begin
      ex_valid   <= take_id;
      ex_pc      <= take_id ? id_pc      : '0;
      ex_rs_data <= take_id ? id_rs_data : '0;
      ex_rt_data <= take_id ? id_rt_data : '0;
      ex_imm_ext <= take_id ? id_imm_ext : '0;
      ex_rs      <= take_id ? id_rs      : '0;
      ex_rt      <= take_id ? id_rt      : '0;
      ex_shamt   <= take_id ? id_shamt   : '0;
      ex_wr_reg  <= take_id ? id_wr_reg  : '0;
      ex_alu_op  <= take_id ? id_alu_op  : '0;
      ex_ctrl    <= take_id ? id_ctrl    : '0;
    end
  end

  // Counters wrap naturally at 2^CNT_W; flush outranks the stall it suppresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (en) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (flush)
        flush_cnt <= flush_cnt + 1'b1;
      else if (load_use_stall)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stalls, flush
// priority, jal destination, hold, async reset and counter wrap.
module tb_id_ex_stage;
  import cpu_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n, en, flush, id_valid;
  logic [DATA_W-1:0] id_pc, id_rs_data, id_rt_data, id_imm_ext;
  logic [4:0]        id_rs, id_rt, id_rd, id_shamt;
  logic [3:0]        id_alu_op;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext;
  logic [4:0]        ex_rs, ex_rt, ex_shamt, ex_wr_reg;
  logic [3:0]        ex_alu_op;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              load_use_stall;
  logic [CNT_W-1:0]  cycle_cnt, bubble_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [CTRL_W-1:0] C_ADD  = (14'd1 << CTRL_REG_DST) | (14'd1 << CTRL_REG_WRITE);
  localparam logic [CTRL_W-1:0] C_LW   = (14'd1 << CTRL_MEM_TO_REG) | (14'd1 << CTRL_ALU_SRC) |
                                         (14'd1 << CTRL_REG_WRITE);
  localparam logic [CTRL_W-1:0] C_SW   = (14'd1 << CTRL_MEM_WRITE) | (14'd1 << CTRL_ALU_SRC);
  localparam logic [CTRL_W-1:0] C_J    = (14'd1 << CTRL_JMP);
  localparam logic [CTRL_W-1:0] C_JAL  = (14'd1 << CTRL_JAL) | (14'd1 << CTRL_REG_WRITE);

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_shamt(ex_shamt),
    .ex_wr_reg(ex_wr_reg), .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
    .load_use_stall(load_use_stall),
    .cycle_cnt(cycle_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [DATA_W-1:0] pc,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [3:0] op, input logic [CTRL_W-1:0] ctrl,
                        input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] rtd,
                        input logic [DATA_W-1:0] imm);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
    id_alu_op = op; id_ctrl = ctrl; id_rs_data = rsd; id_rt_data = rtd; id_imm_ext = imm;
    id_shamt = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    #12;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_stall", load_use_stall, 0);

    rst_n = 1'b1; en = 1'b1;
    step();
    check("first_cycle", cycle_cnt, 1);
    check("idle_ex_valid", ex_valid, 0);

    // add $3,$1,$2
    set_id(1'b1, 32'h0000_0104, 5'd1, 5'd2, 5'd3, ALU_ADD, C_ADD,
           32'h1111_1111, 32'h2222_0000, 32'h0000_1820);
    id_shamt = 5'd4;
    step();
    check("add_valid", ex_valid, 1);
    check("add_wr", ex_wr_reg, 3);
    check("add_op", ex_alu_op, 5);
    check("add_ctrl", ex_ctrl, C_ADD);
    check("add_pc", ex_pc, 32'h0000_0104);
    check("add_rsd", ex_rs_data, 32'h1111_1111);
    check("add_rtd", ex_rt_data, 32'h2222_0000);
    check("add_imm", ex_imm_ext, 32'h0000_1820);
    check("add_rs", ex_rs, 1);
    check("add_rt", ex_rt, 2);
    check("add_shamt", ex_shamt, 4);
    check("add_cycle", cycle_cnt, 2);

    // lw $5,0($1) then add $6,$5,$2
    set_id(1'b1, 32'h108, 5'd1, 5'd5, 5'd0, ALU_ADD, C_LW, 32'h40, 32'h0, 32'h0);
    step();
    check("lw_wr", ex_wr_reg, 5);
    set_id(1'b1, 32'h10c, 5'd5, 5'd2, 5'd6, ALU_ADD, C_ADD, 32'h1, 32'h2, 32'h0);
    #1;
    check("lu_stall", load_use_stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", ex_ctrl, 0);
    check("lu_bubble_wr", ex_wr_reg, 0);
    check("lu_bubble_pc", ex_pc, 0);
    check("lu_bubble_cnt", bubble_cnt, 1);
    check("lu_stall_drop", load_use_stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_wr", ex_wr_reg, 6);
    check("lu_bubble_cnt2", bubble_cnt, 1);

    // lw $0 then add $6,$0,$2: no hazard on $0
    set_id(1'b1, 32'h110, 5'd1, 5'd0, 5'd0, ALU_ADD, C_LW, 32'h0, 32'h0, 32'h0);
    step();
    set_id(1'b1, 32'h114, 5'd0, 5'd2, 5'd6, ALU_ADD, C_ADD, 32'h0, 32'h2, 32'h0);
    #1;
    check("lw0_stall", load_use_stall, 0);
    step();
    check("lw0_add_wr", ex_wr_reg, 6);
    check("lw0_bubble_cnt", bubble_cnt, 1);

    // lw $5 then sw $5,4($2): rt is a source for stores
    set_id(1'b1, 32'h118, 5'd1, 5'd5, 5'd0, ALU_ADD, C_LW, 32'h0, 32'h0, 32'h0);
    step();
    set_id(1'b1, 32'h11c, 5'd2, 5'd5, 5'd0, ALU_ADD, C_SW, 32'h0, 32'h0, 32'h4);
    #1;
    check("sw_stall", load_use_stall, 1);
    flush = 1'b1;
    #1;
    check("flush_stall", load_use_stall, 0);
    step();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_ctrl", ex_ctrl, 0);
    check("flush_cnt", flush_cnt, 1);
    check("flush_bubble_cnt", bubble_cnt, 1);

    // lw $5 then j with rt field 5: rt not a source
    set_id(1'b1, 32'h120, 5'd1, 5'd5, 5'd0, ALU_ADD, C_LW, 32'h0, 32'h0, 32'h0);
    step();
    set_id(1'b1, 32'h124, 5'd0, 5'd5, 5'd0, ALU_ADD, C_J, 32'h0, 32'h0, 32'h0);
    #1;
    check("j_stall", load_use_stall, 0);
    step();
    check("j_valid", ex_valid, 1);
    check("j_ctrl", ex_ctrl, C_J);

    // jal links to $31
    set_id(1'b1, 32'h128, 5'd0, 5'd7, 5'd9, ALU_ADD, C_JAL, 32'h0, 32'h0, 32'h0);
    step();
    check("jal_wr", ex_wr_reg, 31);
    check("cycle_before_hold", cycle_cnt, 12);

    // Hold for three cycles with different ID contents
    en = 1'b0;
    set_id(1'b1, 32'h200, 5'd3, 5'd4, 5'd8, ALU_SUB, C_ADD, 32'h5, 32'h6, 32'h7);
    step(); step(); step();
    check("hold_wr", ex_wr_reg, 31);
    check("hold_pc", ex_pc, 32'h128);
    check("hold_cycle", cycle_cnt, 12);
    check("hold_flush_cnt", flush_cnt, 1);

    // Reset mid-stall
    en = 1'b1;
    set_id(1'b1, 32'h300, 5'd1, 5'd5, 5'd0, ALU_ADD, C_LW, 32'h0, 32'h0, 32'h0);
    step();
    set_id(1'b1, 32'h304, 5'd5, 5'd2, 5'd6, ALU_ADD, C_ADD, 32'h0, 32'h0, 32'h0);
    #1;
    check("pre_rst_stall", load_use_stall, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_stall", load_use_stall, 0);
    check("midrst_valid", ex_valid, 0);
    check("midrst_bubble_cnt", bubble_cnt, 0);
    check("midrst_cycle", cycle_cnt, 0);
    check("midrst_wr", ex_wr_reg, 0);

    // Wrap: 255 edges reach the maximum, one more returns to 0
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 255; i++) step();
    check("wrap_max", cycle_cnt, 255);
    step();
    check("wrap_zero", cycle_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
